soft_mute_ramp: RTL and testbench

- Parametrised successor to the hard mute stage: mutes and unmutes N channels with a linear gain ramp instead of an instant cut, so a mute switch causes no click.
- Sits in the per-sample effect chain between the codec receive path and the downstream effects.
- Registered datapath with a valid strobe.
- State-machine control of a shared gain, with status outputs for LEDs/debug.

---
 rtl/soft_mute_ramp.sv | 107 ++++++++++
 tb/tb_soft_mute_ramp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/soft_mute_ramp.sv
// Soft mute for NUM_CH channels. A shared gain ramps linearly toward 0 or unity,
// so a mute switch fades the audio instead of clicking.
module soft_mute_lane #(
  parameter int WIDTH     = 32,
  parameter int GAIN_BITS = 16
) (
  input  logic signed [WIDTH-1:0]   smp,
  input  logic        [GAIN_BITS:0] g,
  output logic        [WIDTH-1:0]   res
);
  localparam int PW = WIDTH + GAIN_BITS + 2;

  logic signed [PW-1:0] a, b, prod;

  // The gain is zero-extended so it is never read as negative. With g <= FULL
  // the shifted product always fits back into WIDTH bits.
  always_comb begin
    a    = PW'(smp);
    b    = PW'({1'b0, g});
    prod = a * b;
    res  = WIDTH'(prod >>> GAIN_BITS);
  end
endmodule

module soft_mute_ramp #(
  parameter int WIDTH       = 32,
  parameter int NUM_CH      = 2,
  parameter int GAIN_BITS   = 16,
  parameter int RAMP_STEP   = 64,
  parameter bit START_MUTED = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    muted,
  output logic                    ramping
);
  localparam int GW = GAIN_BITS + 1;
  localparam logic [GW-1:0] FULL = GW'(1) << GAIN_BITS;
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);

  typedef enum logic [1:0] {UNMUTED, RAMP_DOWN, MUTED, RAMP_UP} state_t;
  localparam state_t RST_STATE = START_MUTED ? MUTED : UNMUTED;
  localparam logic [GW-1:0] RST_GAIN = START_MUTED ? '0 : FULL;

  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic out_valid_q, out_valid_d;
  logic muted_q, muted_d, ramping_q, ramping_d;
  logic [NUM_CH-1:0][WIDTH-1:0] lane_res, out_data_q, out_data_d;

  // Every lane scales by the gain held before this edge.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    soft_mute_lane #(.WIDTH(WIDTH), .GAIN_BITS(GAIN_BITS)) u_lane (
      .smp (in_data[k*WIDTH +: WIDTH]),
      .g   (g_q),
      .res (lane_res[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    if (in_valid) begin
      out_data_d = lane_res;
      if (enable && state_q != MUTED) begin
        g_d     = (g_q > STEP) ? g_q - STEP : '0;
        state_d = (g_d == '0) ? MUTED : RAMP_DOWN;
      end else if (!enable && state_q != UNMUTED) begin
        // Compare against FULL-STEP so the add cannot overflow GW bits.
        g_d     = (g_q >= FULL - STEP) ? FULL : g_q + STEP;
        state_d = (g_d == FULL) ? UNMUTED : RAMP_UP;
      end
    end
    muted_d   = (state_d == MUTED);
    ramping_d = (state_d == RAMP_DOWN) || (state_d == RAMP_UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      g_q         <= RST_GAIN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      muted_q     <= START_MUTED;
      ramping_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      muted_q     <= muted_d;
      ramping_q   <= ramping_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign muted     = muted_q;
  assign ramping   = ramping_q;
endmodule

// File: tb/tb_soft_mute_ramp.sv
// Three soft-mute instances (step 4, step 16, step 4 starting muted) driven by
// shared stimulus; a gain-only reference model feeds a scoreboard monitor.
module tb_soft_mute_ramp;
  localparam int W    = 16;
  localparam int GB   = 4;
  localparam int FULL = 16;

  typedef struct packed {
    logic [2:0][31:0] data;
    logic [2:0]       m;
    logic [2:0]       r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid;
  logic [31:0] in_data;
  logic        ov [3];
  logic        mu [3];
  logic        ra [3];
  logic [31:0] od [3];

  int   checks = 0;
  int   errors = 0;
  int   mg [3];
  exp_t sbq [$];
  exp_t last, popped;
  logic exp_ov = 1'b0;

  soft_mute_ramp #(.WIDTH(W), .NUM_CH(2), .GAIN_BITS(GB), .RAMP_STEP(4), .START_MUTED(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .muted(mu[0]), .ramping(ra[0]));
  soft_mute_ramp #(.WIDTH(W), .NUM_CH(2), .GAIN_BITS(GB), .RAMP_STEP(16), .START_MUTED(1'b0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .muted(mu[1]), .ramping(ra[1]));
  soft_mute_ramp #(.WIDTH(W), .NUM_CH(2), .GAIN_BITS(GB), .RAMP_STEP(4), .START_MUTED(1'b1)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .muted(mu[2]), .ramping(ra[2]));

  always #5 clk = ~clk;

  function automatic int step_of(int d);
    return (d == 1) ? 16 : 4;
  endfunction

  function automatic bit sm_of(int d);
    return d == 2;
  endfunction

  // floor(s * g / FULL) using plain integer division corrected toward -inf.
  function automatic logic [15:0] scale(logic [15:0] s, int g);
    longint p, q;
    p = longint'($signed(s)) * g;
    q = p / FULL;
    if ((p % FULL) != 0 && p < 0) q = q - 1;
    return 16'(q);
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic chk(string nm, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic set_reset_model();
    for (int d = 0; d < 3; d++) begin
      mg[d]        = sm_of(d) ? 0 : FULL;
      last.data[d] = '0;
      last.m[d]    = sm_of(d);
      last.r[d]    = 1'b0;
    end
  endtask

  // Model holds only the gain: muted iff g==0, ramping iff 0<g<FULL.
  task automatic send(bit en, logic [15:0] l, logic [15:0] r);
    exp_t e;
    enable   = en;
    in_valid = 1'b1;
    in_data  = {r, l};
    for (int d = 0; d < 3; d++) begin
      e.data[d] = {scale(r, mg[d]), scale(l, mg[d])};
      if (en) mg[d] = (mg[d] > step_of(d)) ? mg[d] - step_of(d) : 0;
      else    mg[d] = (mg[d] + step_of(d) < FULL) ? mg[d] + step_of(d) : FULL;
      e.m[d] = (mg[d] == 0);
      e.r[d] = (mg[d] > 0) && (mg[d] < FULL);
    end
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(int n, bit toggle);
    in_valid = 1'b0;
    repeat (n) begin
      if (toggle) enable = ~enable;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; reset is asserted and released away from any edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_out_data", od[d], 0);
      chk("rst_muted", mu[d], sm_of(d));
      chk("rst_ramping", ra[d], 0);
    end
    sbq.delete();
    set_reset_model();
    #8 reset = 1'b0;
    @(negedge clk);
  endtask

  always @(posedge clk or posedge reset)
    if (reset) exp_ov <= 1'b0;
    else       exp_ov <= in_valid;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) chk("out_valid", ov[d], exp_ov);
    if (ov[0]) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=out_valid expected=no_output at %0t", $time);
      end else begin
        popped = sbq.pop_front();
        last   = popped;
      end
    end
    // Outside valid cycles this checks that data and status hold.
    for (int d = 0; d < 3; d++) begin
      chk("out_data", od[d], last.data[d]);
      chk("muted", mu[d], last.m[d]);
      chk("ramping", ra[d], last.r[d]);
    end
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    set_reset_model();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("por_out_valid", ov[d], 0);
      chk("por_muted", mu[d], sm_of(d));
      chk("por_ramping", ra[d], 0);
    end
    #11 reset = 1'b0;
    @(negedge clk);

    send(1'b0, 16'd1000, 16'h8000);
    repeat (5) send(1'b1, 16'd1600, 16'd1600);
    idle(2, 1'b0);

    do_reset();
    repeat (2) send(1'b1, 16'd1600, 16'd1600);
    repeat (4) send(1'b0, 16'd1600, 16'd1600);
    idle(1, 1'b0);

    do_reset();
    repeat (2) send(1'b1, 16'd1600, 16'd1600);
    send(1'b0, 16'hfffd, 16'd3);
    idle(2, 1'b0);

    for (int i = 0; i < 4; i++) begin
      send(i[0], rnd16(), rnd16());
      idle(3, 1'b1);
    end

    do_reset();
    repeat (2) send(1'b1, 16'd1600, 16'd1600);
    do_reset();
    send(1'b0, 16'd1600, 16'hf9c0);
    send(1'b1, 16'd1600, 16'd1600);
    send(1'b1, 16'd1600, 16'd1600);
    idle(2, 1'b0);

    for (int i = 0; i < 300; i++) begin
      bit en;
      int n;
      en = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        send(en, rnd16(), rnd16());
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    idle(3, 1'b0);
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
